// File: rtl/act_bitplane_feeder.sv
// Double-buffered activation feeder: turns one word of M Pa-bit activations into
// M-bit bit-planes (MSB first), replaying the full plane sweep once per weight bit.
module act_bitplane_feeder #(
  parameter int M  = 16,
  parameter int Pa = 8,
  parameter int Pw = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cl_en,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [M*Pa-1:0]       in_act,
  input  logic                  out_en,
  output logic                  plane_valid,
  output logic [M-1:0]          act_plane,
  output logic                  MSB_a,
  output logic                  last_plane,
  output logic [$clog2(Pw)-1:0] pass_idx,
  output logic                  busy
);

  localparam int PAW = $clog2(Pa);
  localparam int PWW = $clog2(Pw);
  localparam logic [PAW-1:0] PLANE_TOP = PAW'(Pa - 1);
  localparam logic [PWW-1:0] PASS_TOP  = PWW'(Pw - 1);

  // The stream state is exactly the "working buffer occupied" flag.
  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic             shad_full_q, shad_full_d;
  logic [PAW-1:0]   plane_q, plane_d;
  logic [PWW-1:0]   pass_q, pass_d;
  logic [M*Pa-1:0]  work_q, work_d;
  logic [M*Pa-1:0]  shad_q, shad_d;

  logic work_full;
  logic accept;
  logic advance;
  logic at_last;
  logic release_work;

  assign work_full    = (state_q == STREAM);
  assign in_ready     = ~shad_full_q;
  assign accept       = in_valid & in_ready;
  assign advance      = work_full & out_en;
  assign at_last      = (plane_q == '0) && (pass_q == PASS_TOP);
  assign release_work = advance & at_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shad_full_q <= 1'b0;
      plane_q     <= '0;
      pass_q      <= '0;
    end else begin
      state_q     <= state_d;
      shad_full_q <= shad_full_d;
      plane_q     <= plane_d;
      pass_q      <= pass_d;
    end
  end

  // Data registers are qualified by their flags, so they carry no reset.
  always_ff @(posedge clk) begin
    work_q <= work_d;
    shad_q <= shad_d;
  end

  always_comb begin
    state_d     = state_q;
    shad_full_d = shad_full_q;
    plane_d     = plane_q;
    pass_d      = pass_q;
    work_d      = work_q;
    shad_d      = shad_q;

    if (cl_en) begin
      state_d     = IDLE;
      shad_full_d = 1'b0;
      plane_d     = '0;
      pass_d      = '0;
    end else begin
      if (advance) begin
        if (plane_q != '0) begin
          plane_d = plane_q - 1'b1;
        end else if (pass_q != PASS_TOP) begin
          plane_d = PLANE_TOP;
          pass_d  = pass_q + 1'b1;
        end else if (shad_full_q) begin
          work_d      = shad_q;
          shad_full_d = 1'b0;
          plane_d     = PLANE_TOP;
          pass_d      = '0;
        end else if (accept) begin
          work_d  = in_act;
          plane_d = PLANE_TOP;
          pass_d  = '0;
        end else begin
          state_d = IDLE;
          plane_d = '0;
          pass_d  = '0;
        end
      end

      // A release edge already consumed any accept above; in_ready is low whenever
      // the shadow is being drained, so the two paths never collide.
      if (accept && !release_work) begin
        if (!work_full) begin
          work_d  = in_act;
          state_d = STREAM;
          plane_d = PLANE_TOP;
          pass_d  = '0;
        end else begin
          shad_d      = in_act;
          shad_full_d = 1'b1;
        end
      end
    end
  end

  always_comb begin
    act_plane = '0;
    for (int j = 0; j < M; j++) begin
      act_plane[j] = work_full & work_q[j*Pa + int'(plane_q)];
    end
  end

  assign plane_valid = work_full;
  assign MSB_a       = work_full & (plane_q == PLANE_TOP);
  assign last_plane  = work_full & at_last;
  assign pass_idx    = pass_q;
  assign busy        = work_full | shad_full_q;

endmodule

// File: tb/tb_act_bitplane_feeder.sv
// Randomized scoreboard bench for act_bitplane_feeder: accepted words are expanded
// into their expected plane sequence, and a monitor pops one entry per consumed plane.
module tb_act_bitplane_feeder;

  localparam int M      = 16;
  localparam int Pa     = 8;
  localparam int Pw     = 8;
  localparam int PLANES = Pa * Pw;

  typedef struct {
    logic [M-1:0] plane;
    logic         msb;
    logic         last;
    logic [2:0]   pass;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            cl_en;
  logic            in_valid;
  logic            in_ready;
  logic [M*Pa-1:0] in_act;
  logic            out_en;
  logic            plane_valid;
  logic [M-1:0]    act_plane;
  logic            MSB_a;
  logic            last_plane;
  logic [2:0]      pass_idx;
  logic            busy;

  exp_t sb[$];
  int   nChecks = 0;
  int   nFails  = 0;

  act_bitplane_feeder #(.M(M), .Pa(Pa), .Pw(Pw)) dut (
    .clk(clk), .rst_n(rst_n), .cl_en(cl_en),
    .in_valid(in_valid), .in_ready(in_ready), .in_act(in_act),
    .out_en(out_en), .plane_valid(plane_valid), .act_plane(act_plane),
    .MSB_a(MSB_a), .last_plane(last_plane), .pass_idx(pass_idx), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    nChecks++;
    if (got !== want) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic bound(input string name, input bit expired);
    nChecks++;
    if (expired) begin
      nFails++;
      $display("[TB] FAIL %s: timeout waiting (got expired, expected completion)", name);
    end
  endtask

  // Reference: every pass sweeps the bits of each activation from MSB down to LSB.
  task automatic pushWord(input logic [M*Pa-1:0] w);
    exp_t e;
    for (int p = 0; p < Pw; p++) begin
      for (int b = Pa - 1; b >= 0; b--) begin
        for (int j = 0; j < M; j++) e.plane[j] = w[j*Pa + b];
        e.msb  = (b == Pa - 1);
        e.last = (p == Pw - 1) && (b == 0);
        e.pass = 3'(p);
        sb.push_back(e);
      end
    end
  endtask

  // Called at posedge+1; the accept decision uses in_ready for the coming edge.
  task automatic applyStimulus(input logic v, input logic [M*Pa-1:0] d, input logic oe, input logic cl);
    bit accepted;
    in_valid = v;
    in_act   = d;
    out_en   = oe;
    cl_en    = cl;
    accepted = v && in_ready && !cl;
    @(posedge clk);
    #1;
    if (accepted && rst_n) pushWord(d);
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_plane_valid"}, 32'(plane_valid), 32'd0);
    checkOutput({tag, "_busy"},        32'(busy),        32'd0);
    checkOutput({tag, "_in_ready"},    32'(in_ready),    32'd1);
    checkOutput({tag, "_act_plane"},   32'(act_plane),   32'd0);
    checkOutput({tag, "_MSB_a"},       32'(MSB_a),       32'd0);
    checkOutput({tag, "_last_plane"},  32'(last_plane),  32'd0);
    checkOutput({tag, "_pass_idx"},    32'(pass_idx),    32'd0);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb.size() > 0 && n < 4 * PLANES) begin
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      n++;
    end
    bound(name, sb.size() > 0);
    sb.delete();
  endtask

  function automatic logic [M*Pa-1:0] randWord();
    logic [M*Pa-1:0] w;
    for (int i = 0; i < M*Pa/32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  // Monitor: the queue mirrors the feeder contents, so occupancy gives the flags.
  always @(negedge clk) begin
    int words;
    if (rst_n) begin
      words = (sb.size() + PLANES - 1) / PLANES;
      checkOutput("plane_valid", 32'(plane_valid), 32'(words > 0));
      checkOutput("busy",        32'(busy),        32'(words > 0));
      checkOutput("in_ready",    32'(in_ready),    32'(words < 2));
      if (sb.size() > 0) begin
        checkOutput("act_plane",  32'(act_plane),  32'(sb[0].plane));
        checkOutput("MSB_a",      32'(MSB_a),      32'(sb[0].msb));
        checkOutput("last_plane", 32'(last_plane), 32'(sb[0].last));
        checkOutput("pass_idx",   32'(pass_idx),   32'(sb[0].pass));
      end else begin
        checkOutput("act_plane_idle",  32'(act_plane),  32'd0);
        checkOutput("MSB_a_idle",      32'(MSB_a),      32'd0);
        checkOutput("last_plane_idle", 32'(last_plane), 32'd0);
      end
      if (cl_en) sb.delete();
      else if (out_en && sb.size() > 0) void'(sb.pop_front());
    end
  end

  initial begin
    logic [M*Pa-1:0] w;
    int n;
    rst_n    = 1'b0;
    cl_en    = 1'b0;
    in_valid = 1'b0;
    in_act   = '0;
    out_en   = 1'b0;
    #12;
    checkIdleOutputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Uniform 8'hA5 word.
    for (int j = 0; j < M; j++) w[j*Pa +: Pa] = 8'hA5;
    applyStimulus(1'b1, w, 1'b1, 1'b0);
    drain("uniform_drain");

    // Lane mapping: activation j = j.
    for (int j = 0; j < M; j++) w[j*Pa +: Pa] = 8'(j);
    applyStimulus(1'b1, w, 1'b1, 1'b0);
    drain("lanes_drain");

    // Back-to-back words.
    applyStimulus(1'b1, randWord(), 1'b1, 1'b0);
    applyStimulus(1'b1, randWord(), 1'b1, 1'b0);
    drain("b2b_drain");

    // Offer a new word exactly on the release edge with the shadow empty.
    applyStimulus(1'b1, randWord(), 1'b1, 1'b0);
    n = 0;
    while (!last_plane && n < 2 * PLANES) begin
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      n++;
    end
    bound("release_wait", !last_plane);
    applyStimulus(1'b1, randWord(), 1'b1, 1'b0);
    drain("release_drain");

    // Stall pattern mid-pass.
    applyStimulus(1'b1, randWord(), 1'b1, 1'b0);
    for (int k = 0; k < 12; k++) applyStimulus(1'b0, '0, (k % 4 == 0) || (k % 4 == 3), 1'b0);
    drain("stall_drain");

    // Clear at plane 20 with the shadow full.
    applyStimulus(1'b1, randWord(), 1'b1, 1'b0);
    applyStimulus(1'b1, randWord(), 1'b1, 1'b0);
    for (int k = 0; k < 18; k++) applyStimulus(1'b0, '0, 1'b1, 1'b0);
    applyStimulus(1'b1, randWord(), 1'b1, 1'b1);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);

    // Asynchronous reset between edges with both buffers occupied.
    applyStimulus(1'b1, randWord(), 1'b1, 1'b0);
    applyStimulus(1'b1, randWord(), 1'b1, 1'b0);
    for (int k = 0; k < 10; k++) applyStimulus(1'b0, '0, 1'b1, 1'b0);
    in_valid = 1'b0;
    out_en   = 1'b0;
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    checkIdleOutputs("async_rst");
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(1'b1, randWord(), 1'b1, 1'b0);
    drain("post_rst_drain");

    // Randomized traffic with stalls and occasional clears.
    for (int k = 0; k < 800; k++) begin
      applyStimulus(1'($urandom_range(0, 1)), randWord(), 1'($urandom_range(0, 3) != 0),
                    1'($urandom_range(0, 99) == 0));
    end
    drain("random_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
